// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48 dot-product MAC controller.
package dsp_mac_pkg;

   localparam int LAT_DEF     = 4;
   localparam int OPM_DLY_DEF = 1;
   localparam int MAXLEN_DEF  = 16;

   // Opmode encodings: X select in [1:0], Z select in [3:2].
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;
   localparam logic [7:0] OPM_HOLD  = 8'h08;
   localparam logic [7:0] OPM_ZERO  = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } state_e;

   typedef struct packed {
      logic valid;
      logic first;
   } tag_t;

endpackage

// File: rtl/dsp_mac_ctrl_if.sv
// Job, operand, DSP-slice and result signals of the MAC controller.
interface dsp_mac_ctrl_if;

   logic               start;
   logic [4:0]         len;
   logic               smp_valid;
   logic               smp_ready;
   logic signed [17:0] smp_a;
   logic signed [17:0] smp_b;
   logic signed [17:0] dsp_A;
   logic signed [17:0] dsp_B;
   logic [17:0]        dsp_D;
   logic [47:0]        dsp_C;
   logic [7:0]         dsp_opmode;
   logic               dsp_carryin;
   logic signed [47:0] dsp_P;
   logic               res_valid;
   logic               res_ready;
   logic signed [47:0] res_data;
   logic               busy;
   logic               len_err;

   modport master (
      output start, len, smp_valid, smp_a, smp_b, dsp_P, res_ready,
      input  smp_ready, dsp_A, dsp_B, dsp_D, dsp_C, dsp_opmode, dsp_carryin,
             res_valid, res_data, busy, len_err
   );

   modport slave (
      input  start, len, smp_valid, smp_a, smp_b, dsp_P, res_ready,
      output smp_ready, dsp_A, dsp_B, dsp_D, dsp_C, dsp_opmode, dsp_carryin,
             res_valid, res_data, busy, len_err
   );

endinterface

// File: rtl/dsp_tag_pipe.sv
// Delays the per-issue (valid, first) tag so opmode meets its product at the post-adder.
module dsp_tag_pipe
   import dsp_mac_pkg::*;
#(
   parameter int DEPTH = OPM_DLY_DEF
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign tag_out = tag_in;
      end else begin : g_pipe
         tag_t pipe_q [DEPTH];
         tag_t pipe_d [DEPTH];

         always_comb begin
            pipe_d[0] = tag_in;
            for (int i = 1; i < DEPTH; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         // NOTE: this array is a shift register, not RAM, so every stage is
         // reset; a stale tag here would mis-steer the first opmode after reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign tag_out = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Sequences signed dot-product jobs through an external DSP48 slice and returns the sum.
module dsp_mac_ctrl
   import dsp_mac_pkg::*;
#(
   parameter int LAT     = LAT_DEF,
   parameter int OPM_DLY = OPM_DLY_DEF,
   parameter int MAXLEN  = MAXLEN_DEF
) (
   input logic            clk,
   input logic            RST,
   dsp_mac_ctrl_if.slave  bus
);

   localparam int DW = $clog2(LAT + 1);

   state_e             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [DW-1:0]      drain_q, drain_d;
   logic               first_q, first_d;
   logic signed [17:0] a_q, a_d;
   logic signed [17:0] b_q, b_d;
   logic signed [47:0] res_q, res_d;
   logic               len_err_q, len_err_d;
   logic               fire;
   logic               len_ok;
   tag_t               tag_in, tag_out;

   assign fire   = bus.smp_valid && (state_q == LOAD);
   assign len_ok = (bus.len != 5'd0) && (int'(bus.len) <= MAXLEN);

   // NOTE: every variable gets a default before the case, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      drain_d   = drain_q;
      first_d   = first_q;
      res_d     = res_q;
      len_err_d = 1'b0;
      a_d       = a_q;
      b_d       = b_q;

      if (fire) begin
         a_d = bus.smp_a;
         b_d = bus.smp_b;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  state_d = LOAD;
                  cnt_d   = bus.len;
                  first_d = 1'b1;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (fire) begin
               first_d = 1'b0;
               cnt_d   = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_d = DRAIN;
                  drain_d = DW'(LAT - 1);
               end
            end
         end
         DRAIN: begin
            // Last drain cycle is the one where dsp_P carries the final sum.
            if (drain_q == '0) begin
               res_d   = bus.dsp_P;
               state_d = DONE;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update
   // together on the edge regardless of statement order.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         drain_q   <= '0;
         first_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         drain_q   <= drain_d;
         first_q   <= first_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         len_err_q <= len_err_d;
      end
   end

   assign tag_in.valid = fire;
   assign tag_in.first = fire && first_q;

   dsp_tag_pipe #(
      .DEPTH (OPM_DLY)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (RST),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   always_comb begin
      if (tag_out.valid) begin
         bus.dsp_opmode = tag_out.first ? OPM_FIRST : OPM_ACC;
      end else begin
         bus.dsp_opmode = bus.busy ? OPM_HOLD : OPM_ZERO;
      end
   end

   assign bus.smp_ready   = (state_q == LOAD);
   assign bus.busy        = (state_q != IDLE);
   assign bus.res_valid   = (state_q == DONE);
   assign bus.res_data    = res_q;
   assign bus.len_err     = len_err_q;
   assign bus.dsp_A       = a_d;
   assign bus.dsp_B       = b_d;
   assign bus.dsp_D       = '0;
   assign bus.dsp_C       = '0;
   assign bus.dsp_carryin = 1'b0;

endmodule
